// File: rtl/cov_host_seq.sv
// Host-side sequencer for the coprimality core: stages m/n in RAM, pulses the
// core, waits for it under a watchdog, then reads back and returns the result.
module cov_host_seq #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int K0          = 0,
  parameter int K1          = 1,
  parameter int K2          = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_m,
  input  logic [DATA_W-1:0] in_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              cov_start,
  input  logic              cov_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    IDLE, WR_M, WR_N, START, WAIT_DONE, RD_REQ, RD_CAP, OUT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_n;
  logic [DATA_W-1:0] r_result;
  logic              r_err;
  logic              r_seenBusy;
  logic [WD_W-1:0]   r_wd;
  logic              w_xfer;
  logic              w_done;
  logic              w_timeout;

  assign in_ready   = (r_state == IDLE) && cov_ready && !reset;
  assign w_xfer     = in_valid && in_ready;
  // A ready core only counts as finished once it has been seen busy.
  assign w_done     = (r_state == WAIT_DONE) && r_seenBusy && cov_ready;
  // Expiry is the cycle in which the watchdog steps onto its saturation value.
  assign w_timeout  = (r_state == WAIT_DONE) && (r_wd >= WD_LAST) && !w_done;
  assign out_result = r_result;
  assign out_err    = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_xfer) w_next = WR_M;
      WR_M:      w_next = WR_N;
      WR_N:      w_next = START;
      START:     w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (w_done)         w_next = RD_REQ;
        else if (w_timeout) w_next = OUT;
      end
      RD_REQ:    w_next = RD_CAP;
      RD_CAP:    w_next = OUT;
      OUT:       if (out_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    out_valid = (r_state == OUT);
    cov_start = (r_state == START);
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      WR_M: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(K0);
        mem_wdata = r_m;
      end
      WR_N: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(K1);
        mem_wdata = r_n;
      end
      RD_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(K2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m        <= '0;
      r_n        <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_seenBusy <= 1'b0;
      r_wd       <= '0;
    end else begin
      if (w_xfer) begin
        r_m <= in_m;
        r_n <= in_n;
      end
      case (r_state)
        START: begin
          r_wd       <= '0;
          r_seenBusy <= 1'b0;
        end
        WAIT_DONE: begin
          if (!cov_ready)     r_seenBusy <= 1'b1;
          if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
          if (w_timeout) begin
            r_result <= '1;
            r_err    <= 1'b1;
          end
        end
        RD_CAP: begin
          r_result <= mem_rdata;
          r_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_host_seq.sv
// Bench for cov_host_seq: RAM plus a coprimality-core stand-in, randomized and
// directed transactions checked against a gcd/timing reference model.
module tb_cov_host_seq;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int K0 = 0;
  localparam int K1 = 1;
  localparam int K2 = 2;
  localparam int TO = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic          cov_start, cov_ready, mem_wr_en, mem_rd_en, busy;
  logic [DW-1:0] in_m, in_n, out_result, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cov_host_seq #(
    .DATA_W(DW), .ADDR_W(AW), .K0(K0), .K1(K1), .K2(K2), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err),
    .cov_start(cov_start), .cov_ready(cov_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // RAM with one-cycle read latency, and a core that goes busy for coreLen
  // cycles after a start pulse and then writes coprime(m,n) to K2.
  logic [DW-1:0] ram [32];
  int            coreLen = 1;
  bit            coreHang = 1'b0;
  int            coreCnt;
  bit            corePend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cov_ready <= 1'b1;
      corePend  <= 1'b0;
      coreCnt   <= 0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
      if (cov_start && !coreHang) begin
        cov_ready <= 1'b0;
        corePend  <= 1'b1;
        coreCnt   <= coreLen;
      end else if (corePend) begin
        if (coreCnt <= 1) begin
          cov_ready <= 1'b1;
          corePend  <= 1'b0;
          ram[K2]   <= (gcd(ram[K0], ram[K1]) == 1) ? 32'd1 : 32'd0;
        end
        coreCnt <= coreCnt - 1;
      end
    end
  end

  // Bus monitor: counts accesses and pulses, remembers the last m/n writes.
  int            cycle = 0, wrCnt = 0, rdCnt = 0, startCnt = 0, protoErr = 0;
  int            k0Cyc = 0, k1Cyc = 0;
  logic [DW-1:0] k0Data = '0, k1Data = '0;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (mem_wr_en) begin
      wrCnt <= wrCnt + 1;
      if (mem_addr == AW'(K0)) begin k0Cyc <= cycle; k0Data <= mem_wdata; end
      if (mem_addr == AW'(K1)) begin k1Cyc <= cycle; k1Data <= mem_wdata; end
    end
    if (mem_rd_en) rdCnt <= rdCnt + 1;
    if (cov_start) startCnt <= startCnt + 1;
    if ((mem_wr_en && mem_rd_en) || (!mem_wr_en && mem_wdata != '0) ||
        (!mem_wr_en && !mem_rd_en && mem_addr != '0))
      protoErr <= protoErr + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] m, input logic [31:0] n,
                               input int busyLen, input bit hang, input int holdCycles,
                               input bit noise, input int resetAt);
    int            lat, guard, w0, r0, s0, expLat;
    bit            expErr;
    logic [31:0]   expRes, heldRes;
    coreLen  = busyLen;
    coreHang = hang;
    expErr   = hang || (busyLen >= TO - 1);
    expRes   = expErr ? 32'hFFFF_FFFF : ((gcd(m, n) == 1) ? 32'd1 : 32'd0);
    expLat   = expErr ? TO + 2 : busyLen + 6;
    w0 = wrCnt; r0 = rdCnt; s0 = startCnt;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_m = m; in_n = n;
    @(negedge clk);
    in_valid = 1'b0; in_m = $urandom; in_n = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (busy) lat++;
      if (noise && lat == 6) begin in_valid = 1'b1; in_m = m + 7; in_n = n + 3; end
      if (noise && lat == 9) in_valid = 1'b0;
      if (resetAt > 0 && lat == resetAt) begin
        reset = 1'b1;
        #1;
        checkOutput("rst_ctrl", {in_ready, out_valid, out_err, cov_start, mem_wr_en, mem_rd_en, busy}, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_result", out_result, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        checkOutput("rst_no_read", rdCnt - r0, 0);
        checkOutput("rst_one_start", startCnt - s0, 1);
        checkOutput("rst_writes", wrCnt - w0, 2);
        checkOutput("rst_idle", {busy, out_valid}, 0);
        return;
      end
      @(negedge clk);
    end
    checkOutput("out_valid_seen", out_valid, 1);
    checkOutput("latency", lat, expLat);
    checkOutput("result", out_result, expRes);
    checkOutput("err", out_err, expErr);
    heldRes = out_result;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold", {out_valid, in_ready, out_err, out_result}, {1'b1, 1'b0, expErr, heldRes});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("back_to_idle", {busy, out_valid}, 0);
    checkOutput("start_pulses", startCnt - s0, 1);
    checkOutput("writes", wrCnt - w0, 2);
    checkOutput("reads", rdCnt - r0, expErr ? 0 : 1);
    checkOutput("wr_consecutive", k1Cyc - k0Cyc, 1);
    checkOutput("wr_m", k0Data, m);
    checkOutput("wr_n", k1Data, n);
    checkOutput("ram_k0", ram[K0], m);
    checkOutput("ram_k1", ram[K1], n);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_m = '0; in_n = '0; out_ready = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {in_ready, out_valid, out_err, cov_start, mem_wr_en, mem_rd_en, busy}, 0);
    checkOutput("reset_result", out_result, 0);
    checkOutput("reset_addr", {mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", in_ready, 1);

    applyStimulus(32'd35, 32'd12, 20, 1'b0, 2, 1'b0, 0);
    for (int t = 0; t < 6; t++)
      applyStimulus($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 12),
                    1'b0, $urandom_range(0, 3), 1'b0, 0);
    applyStimulus(32'd9, 32'd4, 1, 1'b1, 1, 1'b0, 0);
    applyStimulus(32'd8, 32'd6, TO - 2, 1'b0, 0, 1'b0, 0);
    applyStimulus(32'd7, 32'd5, TO - 1, 1'b0, 0, 1'b0, 0);
    applyStimulus(32'd21, 32'd10, 5, 1'b0, 10, 1'b0, 0);
    applyStimulus(32'd14, 32'd15, 10, 1'b0, 1, 1'b1, 0);
    applyStimulus(32'd33, 32'd22, 10, 1'b0, 0, 1'b0, 8);
    applyStimulus(32'd17, 32'd51, 3, 1'b0, 1, 1'b0, 0);
    checkOutput("bus_protocol", protoErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/cov_host_seq.md
COV_HOST_SEQ -- requirements
Module: cov_host_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5, RAM address width.
REQ-003 SHALL have parameters K0/K1/K2, defaults 0/1/2, RAM addresses of m, n and result.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in cycles, >=4.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports in_valid in 1 / in_ready out 1, operand-pair handshake.
REQ-008 SHALL have ports in_m, in_n  in  DATA_W  operands m and n.
REQ-009 SHALL have ports out_valid out 1 / out_ready in 1, result handshake.
REQ-010 SHALL have port out_result  out  DATA_W  result word read from K2.
REQ-011 SHALL have port out_err  out  1  watchdog expiry, qualified by out_valid.
REQ-012 SHALL have port cov_start  out  1  one-cycle start pulse to the coprimality core.
REQ-013 SHALL have port cov_ready  in  1  core idle indicator.
REQ-014 SHALL have ports mem_addr out ADDR_W, mem_wdata out DATA_W, mem_wr_en out 1, mem_rd_en out 1, mem_rdata in DATA_W: host-side RAM port.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, WR_M, WR_N, START, WAIT_DONE, RD_REQ, RD_CAP, OUT.
REQ-017 SHALL assert in_ready only in IDLE with cov_ready=1; transfer occurs on in_valid&in_ready at a rising edge; operands latched that edge.
REQ-018 SHALL, IDLE -> WR_M on transfer; WR_M: mem_wr_en=1, mem_addr=K0, mem_wdata=m.
REQ-019 SHALL, WR_M -> WR_N unconditionally; WR_N: mem_wr_en=1, mem_addr=K1, mem_wdata=n.
REQ-020 SHALL, WR_N -> START; START: cov_start=1 for exactly one cycle; watchdog cleared to 0; seen_busy cleared.
REQ-021 SHALL, in WAIT_DONE, set seen_busy when cov_ready=0, and increment watchdog every cycle.
REQ-022 SHALL, WAIT_DONE -> RD_REQ when seen_busy=1 and cov_ready=1; cov_ready high without prior low SHALL NOT complete.
REQ-023 SHALL, WAIT_DONE -> OUT with out_err=1, out_result all-ones, when watchdog reaches TIMEOUT_CYC-1 and REQ-022 not met the same cycle; completion wins on a simultaneous event.
REQ-024 SHALL, RD_REQ: mem_rd_en=1, mem_addr=K2; RD_REQ -> RD_CAP; RAM read latency is one cycle.
REQ-025 SHALL, RD_CAP: capture mem_rdata into out_result, out_err=0; RD_CAP -> OUT.
REQ-026 SHALL, OUT: out_valid=1, out_result/out_err stable until out_ready=1; OUT -> IDLE on out_valid&out_ready.
REQ-027 SHALL drive mem_wr_en and mem_rd_en never simultaneously, and both 0 outside WR_M, WR_N, RD_REQ; mem_addr/mem_wdata = 0 when not enabled.
REQ-028 SHALL have min latency transfer-to-out_valid = 6 + core busy cycles (WR_M, WR_N, START, >=1 WAIT_DONE, RD_REQ, RD_CAP).
REQ-029 SHALL saturate watchdog at TIMEOUT_CYC-1; no wrap-around.
REQ-030 SHALL ignore in_valid outside IDLE; operands not overwritten mid-transaction.

Reset
REQ-031 SHALL, on reset high at any time, asynchronously enter IDLE; in_ready=0 while reset high, out_valid=0, out_err=0, out_result=0, cov_start=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0, busy=0, watchdog=0, seen_busy=0.
REQ-032 SHALL, on reset mid-transaction, abandon it with no further RAM access or start pulse; first in_ready after release is the cycle after deassertion if cov_ready=1.

Verification
REQ-033 SHALL pass: m=35,n=12 accepted, core model drops cov_ready 1 cycle after start for 20 cycles, writes 1 to K2 -> K0=35, K1=12 written in consecutive cycles, one cov_start pulse, out_result=1, out_err=0.
REQ-034 SHALL pass: core never drops cov_ready, TIMEOUT_CYC=16 -> out_valid 16 cycles after START, out_err=1, out_result=0xFFFFFFFF, no mem_rd_en.
REQ-035 SHALL pass: out_ready held 0 for 10 cycles in OUT -> out_valid/out_result stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-036 SHALL pass: reset asserted in WAIT_DONE -> all outputs per REQ-031 immediately, no later RAM read.
REQ-037 SHALL pass: in_valid toggled with new operands during WAIT_DONE -> ignored; K0/K1 unchanged; only one transaction completes.
REQ-038 SHALL pass: cov_ready returns high on the exact watchdog-expiry cycle -> normal completion, out_err=0.
